lsu_axi_master: RTL and testbench

LSU_AXI_MASTER -- requirements
Module: lsu_axi_master

---
 rtl/lsu_axi_master.sv | 153 +++++++++++++++
 tb/tb_lsu_axi_master.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_axi_master.sv
// rtl/lsu_axi_master.sv - single-outstanding load/store bridge onto an AXI-lite master
module lsu_axi_master (
  input  logic        clk,
  input  logic        rst,
  // core request
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  // core response
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  // read address channel
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  // read data channel
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  // write address channel
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  // write data channel
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  // write response channel
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, RESP} state_t;

  state_t state;
  logic   wen_q;
  logic   aw_done;
  logic   w_done;
  logic   aw_fire;
  logic   w_fire;

  // Address/data handshakes completing this cycle on the write side.
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;

  // Transaction sequencer; every interface output is a register so nothing
  // depends combinationally on the slave ready inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wen_q      <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      araddr     <= 32'h0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awaddr     <= 32'h0;
      awvalid    <= 1'b0;
      wdata      <= 32'h0;
      wstrb      <= 4'h0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            wen_q     <= req_wen;
            if (req_wen) begin
              awaddr  <= req_addr;
              wdata   <= req_wdata;
              wstrb   <= req_wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= AW_W;
            end else begin
              araddr  <= req_addr;
              arvalid <= 1'b1;
              state   <= AR;
            end
          end else begin
            // Also brings req_ready up in the first cycle after reset.
            req_ready <= 1'b1;
          end
        end
        AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= R;
          end
        end
        R: begin
          if (rvalid) begin
            rready     <= 1'b0;
            resp_rdata <= rdata;
            resp_err   <= (rresp != 2'b00);
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        AW_W: begin
          if (aw_fire) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_fire) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          // Both halves done, in whichever order; flags cleared for next write.
          if ((aw_done || aw_fire) && (w_done || w_fire)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bready  <= 1'b1;
            state   <= B;
          end
        end
        B: begin
          if (bvalid) begin
            bready     <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= (bresp != 2'b00);
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          // Never accepts a request here; req_ready only returns once in IDLE.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axi_master.sv
// tb/tb_lsu_axi_master.sv - scoreboard bench for lsu_axi_master with a delay-programmable AXI-lite slave
`timescale 1ns/1ps
module tb_lsu_axi_master;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  lsu_axi_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // slave configuration and handshake counters
  int ar_delay, r_delay, aw_delay, w_delay, b_delay;
  logic [31:0] slv_rdata;
  logic [1:0]  slv_resp;
  int ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0, resp_hs = 0;
  bit aw_first_seen;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_wstrb;

  typedef struct { logic [31:0] rdata; logic err; } resp_t;
  resp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural slave: each ready/valid rises after its programmed wait count.
  initial begin
    int ac, rc, awc, wc, bc;
    ac = 0; rc = 0; awc = 0; wc = 0; bc = 0;
    arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    rdata = 0; rresp = 0; bresp = 0;
    forever begin
      @(posedge clk);
      #1;
      if (arvalid) begin arready = (ac >= ar_delay); ac++; end else begin arready = 0; ac = 0; end
      if (rready) begin rvalid = (rc >= r_delay); rc++; end else begin rvalid = 0; rc = 0; end
      if (awvalid) begin awready = (awc >= aw_delay); awc++; end else begin awready = 0; awc = 0; end
      if (wvalid) begin wready = (wc >= w_delay); wc++; end else begin wready = 0; wc = 0; end
      if (bready) begin bvalid = (bc >= b_delay); bc++; end else begin bvalid = 0; bc = 0; end
      rdata = rvalid ? slv_rdata : 32'hx;
      rresp = slv_resp;
      bresp = slv_resp;
    end
  end

  // Mid-cycle monitor: handshake counting and protocol invariants.
  always @(negedge clk) begin
    if (rst) begin
      if (arvalid) check("araddr_stable", araddr, exp_addr);
      if (awvalid && awready) check("awaddr", awaddr, exp_addr);
      if (wvalid && wready) check("wdata_wstrb", {wstrb, wdata[27:0]}, {exp_wstrb, exp_wdata[27:0]});
      check("rw_exclusive", 32'((arvalid | rready) & (awvalid | wvalid | bready)), 32'd0);
      if (resp_valid) check("req_ready_in_resp", 32'(req_ready), 32'd0);
      if (!awvalid && wvalid) aw_first_seen = 1'b1;
      if (arvalid && arready) ar_hs++;
      if (rvalid && rready) r_hs++;
      if (awvalid && awready) aw_hs++;
      if (wvalid && wready) w_hs++;
      if (bvalid && bready) b_hs++;
      if (resp_valid && resp_ready) resp_hs++;
    end
  end

  task automatic run_txn(input bit wen, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb, input logic [31:0] rd, input logic [1:0] rsp,
                         input int ard, input int rdd, input int awd, input int wdd, input int bd,
                         input int hold, input bit keep_valid);
    int n, t, exp_lat, ar0, aw0, b0, r0, resp0;
    resp_t exp, got_pop;
    logic [31:0] snap_d;
    logic snap_e;
    ar_delay = ard; r_delay = rdd; aw_delay = awd; w_delay = wdd; b_delay = bd;
    slv_rdata = rd; slv_resp = rsp;
    exp_addr = addr; exp_wdata = wd; exp_wstrb = strb;
    aw_first_seen = 1'b0;
    exp_lat = wen ? 3 + ((awd > wdd) ? awd : wdd) + bd : 3 + ard + rdd;
    exp.rdata = wen ? 32'h0 : rd;
    exp.err = (rsp != 2'b00);
    exp_q.push_back(exp);
    ar0 = ar_hs; aw0 = aw_hs; b0 = b_hs; r0 = r_hs; resp0 = resp_hs;
    @(posedge clk); #2;
    req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wd; req_wstrb = strb;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    check("req_accept", 32'(req_ready), 32'd1);
    n = cyc;
    @(posedge clk); #2;
    req_valid = keep_valid;
    t = 0;
    @(negedge clk);
    while (!resp_valid && t < 50) begin @(negedge clk); t++; end
    check("resp_seen", 32'(resp_valid), 32'd1);
    check("latency", 32'(cyc - n), 32'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      snap_d = resp_rdata; snap_e = resp_err;
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_stable", {snap_e, resp_rdata[30:0]}, {resp_err, snap_d[30:0]});
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    got_pop = exp_q.pop_front();
    check("resp_rdata", resp_rdata, got_pop.rdata);
    check("resp_err", 32'(resp_err), 32'(got_pop.err));
    @(posedge clk); #2;
    resp_ready = 1;
    @(posedge clk); #2;
    resp_ready = 0; req_valid = 0;
    repeat (3) @(negedge clk);
    check("resp_count", 32'(resp_hs - resp0), 32'd1);
    check("ar_count", 32'(ar_hs - ar0), wen ? 32'd0 : 32'd1);
    check("r_count", 32'(r_hs - r0), wen ? 32'd0 : 32'd1);
    check("aw_count", 32'(aw_hs - aw0), wen ? 32'd1 : 32'd0);
    check("b_count", 32'(b_hs - b0), wen ? 32'd1 : 32'd0);
    if (wen && awd < wdd) check("aw_drops_first", 32'(aw_first_seen), 32'd1);
  endtask

  initial begin
    int t;
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 0; req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    resp_ready = 0;
    ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0;
    slv_rdata = 0; slv_resp = 0; exp_addr = 0; exp_wdata = 0; exp_wstrb = 0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_valids", 32'({arvalid, awvalid, wvalid, rready, bready, resp_valid}), 32'd0);
    check("rst_resp", {resp_err, resp_rdata[30:0]}, 32'd0);
    check("rst_addr", araddr | awaddr, 32'd0);
    check("rst_wdata", wdata | 32'(wstrb), 32'd0);
    rst = 1;
    @(negedge clk);
    check("req_ready_after_rst", 32'(req_ready), 32'd1);

    // zero-wait read
    run_txn(0, 32'h8000_0010, 0, 0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    // zero-wait write
    run_txn(1, 32'h1000_0004, 32'h1234_5678, 4'hF, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    // UART-style write: awready two cycles ahead of wready
    run_txn(1, 32'hA000_03F8, 32'h0000_0041, 4'b0001, 0, 2'b00, 0, 0, 0, 2, 0, 0, 0);
    // read, arready late by 3, SLVERR
    run_txn(0, 32'h2000_0100, 0, 0, 32'hCAFE_F00D, 2'b10, 3, 0, 0, 0, 0, 0, 0);
    // read with resp backpressure and req_valid kept high
    run_txn(0, 32'h3000_0008, 0, 0, 32'h0BAD_CAFE, 2'b00, 0, 1, 0, 0, 0, 4, 1);
    // write, wready before awready, delayed bvalid, DECERR
    run_txn(1, 32'h4000_0040, 32'h5555_AAAA, 4'b1100, 0, 2'b11, 0, 0, 2, 0, 1, 0, 0);

    // reset while in AW_W
    aw_delay = 10; w_delay = 10; b_delay = 0; slv_resp = 0;
    exp_addr = 32'h5000_0000; exp_wdata = 32'h77; exp_wstrb = 4'hF;
    t = resp_hs;
    @(posedge clk); #2;
    req_valid = 1; req_wen = 1; req_addr = 32'h5000_0000; req_wdata = 32'h77; req_wstrb = 4'hF;
    @(posedge clk); #2;
    req_valid = 0;
    @(negedge clk);
    check("aw_w_before_rst", 32'({awvalid, wvalid}), 32'd3);
    @(posedge clk); #3;
    rst = 0;
    #1;
    check("rst_async_awwvalid", 32'({awvalid, wvalid}), 32'd0);
    check("rst_async_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("req_ready_after_rst2", 32'(req_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("no_resp_after_abort", 32'(resp_hs - t), 32'd0);
    check("no_resp_valid_after_abort", 32'(resp_valid), 32'd0);

    run_txn(0, 32'h6000_0020, 0, 0, 32'h1357_9BDF, 2'b00, 0, 0, 0, 0, 0, 0, 0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
